// File: rtl/car_sensor_iface.sv
// Vehicle loop detector front end: synchronize, debounce and latch EW/NS service requests.
// Optional saturating wait-time counters are enabled with macro TRAFFIC_WAIT_CNT_EN.
module car_sensor_iface #(
   parameter int unsigned DEBOUNCE = 4,
   parameter int unsigned WAIT_W   = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ew_loop_raw,
   input  logic              ns_loop_raw,
   input  logic              EWLite,
   input  logic              NSLite,
   output logic              EWCar,
   output logic              NSCar,
   output logic [WAIT_W-1:0] ew_wait,
   output logic [WAIT_W-1:0] ns_wait
);

   typedef enum logic [1:0] {ABSENT, RISE, PRESENT, FALL} deb_state_t;

   localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE);

   // Index 0 is east-west, index 1 is north-south.
   logic [1:0] raw, lite;
   logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0] deb;
   logic [1:0] req_q, req_d;
   deb_state_t state_q [2];
   deb_state_t state_d [2];
   logic [7:0] cnt_q [2];
   logic [7:0] cnt_d [2];

   assign raw  = {ns_loop_raw, ew_loop_raw};
   assign lite = {NSLite, EWLite};

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      deb     = '0;
      req_d   = req_q;
      for (int unsigned i = 0; i < 2; i++) begin
         case (state_q[i])
            ABSENT: begin
               if (sync2_q[i]) begin
                  state_d[i] = RISE;
                  cnt_d[i]   = 8'd1;
               end
            end
            RISE: begin
               if (!sync2_q[i]) begin
                  state_d[i] = ABSENT;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DEB_MAX) begin
                  state_d[i] = PRESENT;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 8'd1;
               end
            end
            PRESENT: begin
               deb[i] = 1'b1;
               if (!sync2_q[i]) begin
                  state_d[i] = FALL;
                  cnt_d[i]   = 8'd1;
               end
            end
            FALL: begin
               deb[i] = 1'b1;
               if (sync2_q[i]) begin
                  state_d[i] = PRESENT;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DEB_MAX) begin
                  state_d[i] = ABSENT;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 8'd1;
               end
            end
            default: begin
               state_d[i] = ABSENT;
               cnt_d[i]   = '0;
            end
         endcase
         // Own green clears the request and takes priority over a new set.
         if (lite[i]) req_d[i] = 1'b0;
         else if (deb[i]) req_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         req_q   <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            state_q[i] <= ABSENT;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         req_q   <= req_d;
         for (int unsigned i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign EWCar = req_q[0];
   assign NSCar = req_q[1];

`ifdef TRAFFIC_WAIT_CNT_EN
   logic [WAIT_W-1:0] wait_q [2];
   logic [WAIT_W-1:0] wait_d [2];

   always_comb begin
      wait_d = wait_q;
      for (int unsigned i = 0; i < 2; i++) begin
         if (!req_q[i]) wait_d[i] = '0;
         else if (wait_q[i] != '1) wait_d[i] = wait_q[i] + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 2; i++) wait_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) wait_q[i] <= wait_d[i];
      end
   end

   assign ew_wait = wait_q[0];
   assign ns_wait = wait_q[1];
`else
   assign ew_wait = '0;
   assign ns_wait = '0;
`endif

endmodule

// File: tb/tb_car_sensor_iface.sv
// Directed self-checking bench for car_sensor_iface (DEBOUNCE=4, WAIT_W=8).
module tb_car_sensor_iface;

   logic       clock;
   logic       reset;
   logic       ew_loop_raw, ns_loop_raw;
   logic       EWLite, NSLite;
   logic       EWCar, NSCar;
   logic [7:0] ew_wait, ns_wait;

   int tests;
   int fails;

   car_sensor_iface #(.DEBOUNCE(4), .WAIT_W(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .ew_loop_raw (ew_loop_raw),
      .ns_loop_raw (ns_loop_raw),
      .EWLite      (EWLite),
      .NSLite      (NSLite),
      .EWCar       (EWCar),
      .NSCar       (NSCar),
      .ew_wait     (ew_wait),
      .ns_wait     (ns_wait)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Holds reset across an edge and releases it on a falling edge with all inputs low.
   task automatic apply_reset();
      reset = 1'b1;
      ew_loop_raw = 1'b0;
      ns_loop_raw = 1'b0;
      EWLite = 1'b0;
      NSLite = 1'b0;
      tick();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ew_loop_raw = 1'b1;
      ns_loop_raw = 1'b1;
      EWLite = 1'b0;
      NSLite = 1'b0;
      tick();
      tick();
      tests++; if (EWCar !== 1'b0) begin fails++; $display("FAIL reset_ewcar: got %b want 0", EWCar); end
      tests++; if (NSCar !== 1'b0) begin fails++; $display("FAIL reset_nscar: got %b want 0", NSCar); end
      tests++; if (ew_wait !== 8'd0) begin fails++; $display("FAIL reset_ew_wait: got %0d want 0", ew_wait); end
      tests++; if (ns_wait !== 8'd0) begin fails++; $display("FAIL reset_ns_wait: got %0d want 0", ns_wait); end
   endtask

   task automatic test_latency();
      apply_reset();
      EWLite = 1'b0;
      NSLite = 1'b1;
      ew_loop_raw = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         tests++;
         if (EWCar !== (k >= 7)) begin
            fails++; $display("FAIL latency_ewcar edge %0d: got %b want %b", k, EWCar, (k >= 7));
         end
      end
      tests++; if (NSCar !== 1'b0) begin fails++; $display("FAIL latency_nscar: got %b want 0", NSCar); end
   endtask

   task automatic test_bounce();
      apply_reset();
      EWLite = 1'b0;
      NSLite = 1'b1;
      for (int c = 0; c < 48; c++) begin
         ew_loop_raw = (c % 4) != 3;
         tick();
         tests++;
         if (EWCar !== 1'b0) begin
            fails++; $display("FAIL bounce_ewcar cycle %0d: got %b want 0", c, EWCar);
         end
      end
   endtask

   task automatic test_lite_pulse();
      apply_reset();
      EWLite = 1'b0;
      NSLite = 1'b1;
      ew_loop_raw = 1'b1;
      repeat (8) tick();
      tests++; if (EWCar !== 1'b1) begin fails++; $display("FAIL pulse_set: got %b want 1", EWCar); end
      EWLite = 1'b1;
      tick();
      tests++; if (EWCar !== 1'b0) begin fails++; $display("FAIL pulse_clear: got %b want 0", EWCar); end
      EWLite = 1'b0;
      tick();
      tests++; if (EWCar !== 1'b1) begin fails++; $display("FAIL pulse_reassert: got %b want 1", EWCar); end
      ew_loop_raw = 1'b0;
      repeat (20) tick();
      tests++; if (EWCar !== 1'b1) begin fails++; $display("FAIL held_after_leave: got %b want 1", EWCar); end
      EWLite = 1'b1;
      tick();
      tests++; if (EWCar !== 1'b0) begin fails++; $display("FAIL leave_clear: got %b want 0", EWCar); end
      EWLite = 1'b0;
      tick();
      tests++; if (EWCar !== 1'b0) begin fails++; $display("FAIL no_reassert_absent: got %b want 0", EWCar); end
   endtask

   task automatic test_both_lite();
      apply_reset();
      EWLite = 1'b0;
      NSLite = 1'b0;
      ew_loop_raw = 1'b1;
      ns_loop_raw = 1'b1;
      repeat (8) tick();
      tests++; if ({EWCar, NSCar} !== 2'b11) begin fails++; $display("FAIL both_held: got %b%b want 11", EWCar, NSCar); end
      EWLite = 1'b1;
      NSLite = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         tests++;
         if ({EWCar, NSCar} !== 2'b00) begin
            fails++; $display("FAIL both_lite cycle %0d: got %b%b want 00", c, EWCar, NSCar);
         end
      end
      EWLite = 1'b0;
      NSLite = 1'b0;
      tick();
      tests++; if ({EWCar, NSCar} !== 2'b11) begin fails++; $display("FAIL both_resume: got %b%b want 11", EWCar, NSCar); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      EWLite = 1'b1;
      NSLite = 1'b0;
      ns_loop_raw = 1'b1;
      repeat (8) tick();
      tests++; if (NSCar !== 1'b1) begin fails++; $display("FAIL mid_nscar_set: got %b want 1", NSCar); end
      ns_loop_raw = 1'b0;
      repeat (12) tick();
      tests++; if (NSCar !== 1'b1) begin fails++; $display("FAIL mid_nscar_held: got %b want 1", NSCar); end
      ns_loop_raw = 1'b1;
      repeat (4) tick();
      #2;
      reset = 1'b1;
      #1;
      tests++; if (NSCar !== 1'b0) begin fails++; $display("FAIL mid_async_nscar: got %b want 0", NSCar); end
      tests++; if (EWCar !== 1'b0) begin fails++; $display("FAIL mid_async_ewcar: got %b want 0", EWCar); end
      tests++; if (ns_wait !== 8'd0) begin fails++; $display("FAIL mid_async_ns_wait: got %0d want 0", ns_wait); end
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         tests++;
         if (NSCar !== (k >= 7)) begin
            fails++; $display("FAIL mid_relatency edge %0d: got %b want %b", k, NSCar, (k >= 7));
         end
      end
   endtask

   task automatic test_wait();
      apply_reset();
      EWLite = 1'b0;
      NSLite = 1'b0;
      ew_loop_raw = 1'b1;
      repeat (8) tick();
      tests++; if (EWCar !== 1'b1) begin fails++; $display("FAIL wait_car_set: got %b want 1", EWCar); end
      tests++; if (ew_wait !== 8'd0) begin fails++; $display("FAIL wait_start: got %0d want 0", ew_wait); end
`ifdef TRAFFIC_WAIT_CNT_EN
      repeat (10) tick();
      tests++; if (ew_wait !== 8'd10) begin fails++; $display("FAIL wait_ten: got %0d want 10", ew_wait); end
      repeat (300) tick();
      tests++; if (ew_wait !== 8'd255) begin fails++; $display("FAIL wait_sat: got %0d want 255", ew_wait); end
      tick();
      tests++; if (ew_wait !== 8'd255) begin fails++; $display("FAIL wait_sat_hold: got %0d want 255", ew_wait); end
      EWLite = 1'b1;
      tick();
      tests++; if (EWCar !== 1'b0) begin fails++; $display("FAIL wait_car_clear: got %b want 0", EWCar); end
      tick();
      tests++; if (ew_wait !== 8'd0) begin fails++; $display("FAIL wait_cleared: got %0d want 0", ew_wait); end
`else
      repeat (300) tick();
      tests++; if (ew_wait !== 8'd0) begin fails++; $display("FAIL wait_disabled_ew: got %0d want 0", ew_wait); end
`endif
      tests++; if (ns_wait !== 8'd0) begin fails++; $display("FAIL wait_ns_idle: got %0d want 0", ns_wait); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_latency();
      test_bounce();
      test_lite_pulse();
      test_both_lite();
      test_reset_mid();
      test_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
